oam_dma_master: RTL and testbench
=================================

// Module: oam_dma_master
// PURPOSE
//  Bus initiator for the FE00-FE9F OAM region: on a start pulse (CPU write to FF46) copies LEN bytes
//  from {src_page,8'h00} to DST_BASE over the shared databus/address/OE/WE memory interface.
//  Requests the bus from the CPU-side arbiter and drives the same strobes the CPU does.
//  The system integrator muxes its address/OE/WE onto the bus while bus_own=1.
// PARAMETERS
//  LEN       160       bytes per transfer (1..256)
//  DST_BASE  16'hFE00  first destination address
// PORTS
//  clk        in     1   system clock; all state changes on posedge
//  rst_n      in     1   asynchronous, active-low reset
//  start      in     1   one-cycle request pulse; sampled on posedge
//  src_page   in     8   source high byte, sampled with start
//  bus_grant  in     1   arbiter grant; level
//  bus_req    out    1   bus request; level
//  bus_own    out    1   =bus_grant & (state READ|WRITE); this block owns the bus this cycle
//  address    out    16  bus address; 0 when !bus_own
//  OE         out    1   read strobe; 0 when !bus_own
//  WE         out    1   write strobe; 0 when !bus_own
//  databus    inout  8   driven only in WRITE with bus_own, else 8'bz
//  busy       out    1   transfer accepted and not yet complete
//  done       out    1   one-cycle pulse after final write
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, data_q=0. Outputs: bus_req=0, bus_own=0, address=0,
//   OE=0, WE=0, busy=0, done=0, databus=Z. All take effect immediately, not on a clock edge.
//  src_eff: src_page>=8'hE0 ? src_page-8'h20 : src_page. This maps echo RAM and folds FE/FF to DE/DF.
//   Latched with start.
//  States:
//   IDLE  -- start -> REQ.
//   REQ   -- bus_req=1. bus_grant -> READ with idx=0.
//   READ  -- address={src_eff,idx}, OE=1, WE=0. Memory read is combinational.
//            At posedge with grant: data_q<=databus and go to WRITE.
//   WRITE -- address=DST_BASE+idx, WE=1, OE=0, databus=data_q. Memory commits at posedge.
//            With grant: idx==LEN-1 -> DONE, else idx++ and go to READ.
//   DONE  -- done=1, bus_req=0, busy=0 for one cycle -> IDLE.
//  bus_req=1 and busy=1 in REQ/READ/WRITE.
//  Throughput: 2 cycles/byte. Once start is sampled with grant already high, done asserts on the
//   (2*LEN+1)th following posedge (321 for LEN=160).
//  Grant loss: in READ or WRITE with bus_grant=0, state, idx and data_q hold and the strobes are 0.
//   The same phase re-executes when grant returns, so no byte is skipped or duplicated.
//  start while busy (REQ/READ/WRITE): restart. Re-latch src_eff, idx=0, go to REQ.
//   Prior partial OAM contents are left as-is; no done for the aborted run.
//  start in the DONE cycle: done still pulses, then REQ (restart).
//  idx is 8-bit; address low byte = idx, no carry into the page.
//  DST_BASE+idx uses 16-bit add; LEN<=256 guarantees no wrap past FFFF for the default.
//  WE and OE are never both 1. databus is never driven while OE=1.
// STRUCTURE
//  Shared package gb_bus_pkg: dma_state_t enum {IDLE,REQ,READ,WRITE,DONE}; OAM_BASE=16'hFE00;
//   OAM_LEN=160; DMA_REG_ADDR=16'hFF46; ECHO_BASE_PAGE=8'hE0.
//  No sub-module. Counter, address generation and FSM are inline.
//  Tristate uses a single continuous assign on databus.
// TESTING (bench: memoryunit instance + arbiter model + bus mux)
//  1 Preload C000+i=i^8'h5A, start src_page=C0, grant tied 1 -> FE00+i=i^5A for i<160;
//    done on posedge 321 after start; exactly one done pulse.
//  2 Same with grant delayed 5 cycles -> bus_req=1, OE=WE=0 during wait; done at posedge 326.
//  3 Drop grant for 3 cycles at idx=80 in READ, then in WRITE at idx=120 -> strobes 0 and
//    databus Z while dropped; final OAM correct; done delayed by exactly 6 cycles.
//  4 src_page=E1, C100+i=~i -> reads come from C100-C19F; FE00+i=~i.
//  5 Restart: start at idx=50 with src_page=C1 -> idx resets, single done,
//    all 160 OAM bytes equal C1xx data.
//  6 rst_n=0 mid-WRITE at idx=30 -> outputs reset asynchronously, databus Z within the same cycle;
//    after release the block stays IDLE until the next start.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// Shared Game Boy bus definitions: DMA state encoding, OAM geometry and the
// source-page folding rule used when the DMA engine latches its source.
package gb_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        DONE
    } dma_state_t;

    localparam logic [15:0] OAM_BASE       = 16'hFE00;
    localparam int          OAM_LEN        = 160;
    localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
    localparam logic [7:0]  ECHO_BASE_PAGE = 8'hE0;

    // Echo RAM pages map back onto work RAM; FE/FF fold to DE/DF the same way.
    function automatic logic [7:0] effectiveSrcPage(input logic [7:0] page);
        return (page >= ECHO_BASE_PAGE) ? page - 8'h20 : page;
    endfunction

endpackage

// File: rtl/oam_dma_master.sv
// OAM DMA bus initiator: copies LEN bytes from {src_page,00} to DST_BASE,
// alternating one read and one write cycle per byte while the arbiter grants the bus.
module oam_dma_master
    import gb_bus_pkg::*;
#(
    parameter int          LEN      = OAM_LEN,
    parameter logic [15:0] DST_BASE = OAM_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  src_page,
    input  logic        bus_grant,
    output logic        bus_req,
    output logic        bus_own,
    output logic [15:0] address,
    output logic        OE,
    output logic        WE,
    inout  wire  [7:0]  databus,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    dma_state_t r_state;
    logic [7:0] r_idx;
    logic [7:0] r_data_q;
    logic [7:0] r_src;

    logic w_active;
    logic w_own;
    logic w_read;
    logic w_write;

    // A start pulse always wins, so it restarts a run from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= 8'h00;
            r_data_q <= 8'h00;
            r_src    <= 8'h00;
        end else if (start) begin
            r_state <= REQ;
            r_idx   <= 8'h00;
            r_src   <= effectiveSrcPage(src_page);
        end else begin
            case (r_state)
                IDLE: r_state <= IDLE;
                REQ: begin
                    if (bus_grant) begin
                        r_state <= READ;
                        r_idx   <= 8'h00;
                    end
                end
                READ: begin
                    if (bus_grant) begin
                        r_data_q <= databus;
                        r_state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus_grant) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 8'h01;
                            r_state <= READ;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Without grant the phase simply stalls; strobes drop so the CPU side sees a quiet bus.
    assign w_active = (r_state == READ) || (r_state == WRITE);
    assign w_own    = bus_grant && w_active;
    assign w_read   = w_own && (r_state == READ);
    assign w_write  = w_own && (r_state == WRITE);

    assign bus_req = (r_state == REQ) || w_active;
    assign busy    = bus_req;
    assign done    = (r_state == DONE);
    assign bus_own = w_own;
    assign OE      = w_read;
    assign WE      = w_write;

    assign address = w_read  ? {r_src, r_idx} :
                     w_write ? DST_BASE + {8'h00, r_idx} :
                               16'h0000;

    assign databus = w_write ? r_data_q : 8'bz;

endmodule

// File: tb/tb_oam_dma_master.sv
// Bench for oam_dma_master: flat memory, bus mux and an arbiter driven from
// a per-cycle grant schedule; a step-count model checks the bus every cycle.
module tb_oam_dma_master;
    import gb_bus_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cpuWe;
    logic [15:0] cpuAddr;
    logic [7:0]  cpuData;
    logic        bus_grant;
    logic        start;
    logic [7:0]  src_page;
    logic        bus_req;
    logic        bus_own;
    logic [15:0] address;
    logic        OE;
    logic        WE;
    wire  [7:0]  databus;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];
    logic        tbWe;
    logic [15:0] tbAddr;
    logic [7:0]  tbData;
    logic [15:0] busAddr;
    logic        busOE;
    logic        busWE;

    int compared;
    int mismatched;

    bit          mBusy;
    bit          mWait;
    bit          mDone;
    int          mStep;
    logic [7:0]  mSrc;
    logic        expOwn;
    logic        expRead;
    logic [7:0]  expByte;
    logic [15:0] expAddr;

    oam_dma_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_page  (src_page),
        .bus_grant (bus_grant),
        .bus_req   (bus_req),
        .bus_own   (bus_own),
        .address   (address),
        .OE        (OE),
        .WE        (WE),
        .databus   (databus),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The DMA is kicked by a CPU write to its register.
    assign start    = cpuWe && (cpuAddr == DMA_REG_ADDR);
    assign src_page = cpuData;

    assign busAddr = bus_own ? address : 16'h0000;
    assign busOE   = bus_own && OE;
    assign busWE   = bus_own && WE;
    assign databus = busOE ? mem[busAddr] : 8'bz;

    always @(posedge clk) begin
        if (busWE)
            mem[busAddr] <= databus;
        else if (tbWe)
            mem[tbAddr] <= tbData;
    end

    function automatic logic [7:0] srcByte(input logic [7:0] page, input logic [7:0] idx);
        return (page == 8'hC0) ? (idx ^ 8'h5A) : ~idx;
    endfunction

    function automatic logic [7:0] foldPage(input logic [7:0] page);
        return (page >= 8'd224) ? page - 8'd32 : page;
    endfunction

    function automatic logic grantLevel(input int n, input int delay, input int a, input int b);
        if (n < delay) return 1'b0;
        if (a >= 0 && n >= a && n < a + 3) return 1'b0;
        if (b >= 0 && n >= b && n < b + 3) return 1'b0;
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a run is a request wait followed by 2*LEN granted steps (even = read, odd = write).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy <= 1'b0;
            mWait <= 1'b0;
            mDone <= 1'b0;
            mStep <= 0;
            mSrc  <= 8'h00;
        end else begin
            mDone <= 1'b0;
            if (start) begin
                mBusy <= 1'b1;
                mWait <= 1'b1;
                mStep <= 0;
                mSrc  <= foldPage(src_page);
            end else if (mBusy) begin
                if (mWait) begin
                    if (bus_grant) mWait <= 1'b0;
                end else if (bus_grant) begin
                    if (mStep == 2 * 160 - 1) begin
                        mBusy <= 1'b0;
                        mDone <= 1'b1;
                    end
                    mStep <= mStep + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_bus_req", bus_req, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_address", address, 0);
            checkOutput("rst_strobes", {OE, WE, bus_own, done}, 0);
        end else begin
            expOwn  = mBusy && !mWait && bus_grant;
            expByte = 8'(mStep / 2);
            expRead = (mStep % 2) == 0;
            expAddr = !expOwn ? 16'h0000 :
                      expRead ? {mSrc, expByte} : 16'hFE00 + {8'h00, expByte};
            checkOutput("bus_req", bus_req, mBusy);
            checkOutput("busy", busy, mBusy);
            checkOutput("done", done, mDone);
            checkOutput("bus_own", bus_own, expOwn);
            checkOutput("address", address, expAddr);
            checkOutput("OE", OE, expOwn && expRead);
            checkOutput("WE", WE, expOwn && !expRead);
            checkOutput("oe_we_excl", OE && WE, 0);
            if (expOwn)
                checkOutput("databus", databus, srcByte(mSrc, expByte));
        end
    end

    task automatic loadByte(input logic [15:0] addr, input logic [7:0] data);
        tbAddr = addr;
        tbData = data;
        tbWe   = 1'b1;
        @(posedge clk);
        #1;
        tbWe = 1'b0;
    endtask

    task automatic clearOam();
        for (int i = 0; i < 160; i++) loadByte(16'hFE00 + 16'(i), 8'h00);
    endtask

    task automatic checkOam(input string name, input logic [7:0] page);
        int errs;
        errs = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== srcByte(page, 8'(i))) errs++;
        checkOutput(name, errs, 0);
    endtask

    // Runs one transfer; edge 0 is the posedge that samples the start write.
    task automatic applyStimulus(input logic [7:0] page, input int grantDelay, input int dropA,
                                 input int dropB, input int restartAt, input logic [7:0] restartPage,
                                 input int resetAt, output int doneEdge, output int doneCount);
        int n;
        int limit;
        bit stop;
        doneEdge  = -1;
        doneCount = 0;
        stop      = 1'b0;
        limit     = (resetAt >= 0) ? resetAt + 25 : 1000;
        cpuAddr   = DMA_REG_ADDR;
        cpuData   = page;
        cpuWe     = 1'b1;
        bus_grant = (grantDelay == 0);
        @(posedge clk);
        #1;
        n         = 0;
        cpuWe     = 1'b0;
        bus_grant = grantLevel(0, grantDelay, dropA, dropB);
        while (!stop) begin
            @(posedge clk);
            n++;
            #1;
            if (done) begin
                doneCount++;
                if (doneEdge < 0) doneEdge = n;
            end
            bus_grant = grantLevel(n, grantDelay, dropA, dropB);
            cpuWe     = (n == restartAt);
            cpuData   = restartPage;
            if (resetAt >= 0 && n == resetAt + 3) rst_n = 1'b1;
            if (n == resetAt) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("async_bus_req", bus_req, 0);
                checkOutput("async_busy", busy, 0);
                checkOutput("async_WE", WE, 0);
                checkOutput("async_address", address, 0);
            end
            if ((doneEdge >= 0 && n >= doneEdge + 4) || n >= limit) stop = 1'b1;
        end
    endtask

    initial begin
        int doneEdge;
        int doneCount;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        cpuWe      = 1'b0;
        cpuAddr    = 16'h0000;
        cpuData    = 8'h00;
        bus_grant  = 1'b0;
        tbWe       = 1'b0;
        tbAddr     = 16'h0000;
        tbData     = 8'h00;
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_bus_req", bus_req, 0);
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 160; i++) loadByte(16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
        for (int i = 0; i < 160; i++) loadByte(16'hC100 + 16'(i), ~8'(i));

        $display("[TB] copy C0 page, grant held");
        clearOam();
        applyStimulus(8'hC0, 0, -1, -1, -1, 8'h00, -1, doneEdge, doneCount);
        checkOutput("t1_done_edge", doneEdge, 321);
        checkOutput("t1_done_count", doneCount, 1);
        checkOutput("t1_oam_first", mem[16'hFE00], 8'h5A);
        checkOutput("t1_oam_last", mem[16'hFE9F], 8'hC5);
        checkOam("t1_oam", 8'hC0);

        $display("[TB] grant delayed five cycles");
        clearOam();
        applyStimulus(8'hC0, 5, -1, -1, -1, 8'h00, -1, doneEdge, doneCount);
        checkOutput("t2_done_edge", doneEdge, 326);
        checkOutput("t2_done_count", doneCount, 1);
        checkOam("t2_oam", 8'hC0);

        $display("[TB] grant dropped in READ idx 80 and WRITE idx 120");
        clearOam();
        applyStimulus(8'hC0, 0, 161, 245, -1, 8'h00, -1, doneEdge, doneCount);
        checkOutput("t3_done_edge", doneEdge, 327);
        checkOutput("t3_done_count", doneCount, 1);
        checkOam("t3_oam", 8'hC0);

        $display("[TB] echo page E1 folds to C1");
        clearOam();
        applyStimulus(8'hE1, 0, -1, -1, -1, 8'h00, -1, doneEdge, doneCount);
        checkOutput("t4_done_edge", doneEdge, 321);
        checkOutput("t4_oam_first", mem[16'hFE00], 8'hFF);
        checkOutput("t4_oam_last", mem[16'hFE9F], 8'h60);
        checkOam("t4_oam", 8'hC1);

        $display("[TB] restart at idx 50 with page C1");
        clearOam();
        applyStimulus(8'hC0, 0, -1, -1, 101, 8'hC1, -1, doneEdge, doneCount);
        checkOutput("t5_done_edge", doneEdge, 423);
        checkOutput("t5_done_count", doneCount, 1);
        checkOutput("t5_oam_idx50", mem[16'hFE32], 8'hCD);
        checkOam("t5_oam", 8'hC1);

        $display("[TB] reset during WRITE idx 30");
        applyStimulus(8'hC0, 0, -1, -1, -1, 8'h00, 62, doneEdge, doneCount);
        checkOutput("t6_done_count", doneCount, 0);
        checkOutput("t6_idle_busy", busy, 0);
        checkOutput("t6_idle_req", bus_req, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
